// File: rtl/outputc_vc.sv
`default_nettype none
// ============================================================================
// outputc_vc : output-channel controller -- link register, per-VC credit
//              counters and per-VC lock FSM (checker: OUTPUTC_VC_CHK_EN)
// Revision   : 1.0
// ============================================================================
module outputc_vc #(
  parameter  int VCH_N     = 2,
  parameter  int FLIT_W    = 64,
  parameter  int BUF_DEPTH = 4,
  parameter  int PKT_LEN   = 4,
  parameter  int RDY_PKT   = 1,
  localparam int VCH_W     = (VCH_N > 1) ? $clog2(VCH_N) : 1,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [VCH_W-1:0]  in_vch,
  input  logic [FLIT_W-1:0] in_data,
  input  logic [VCH_N-1:0]  cred_i,
  input  logic [VCH_N-1:0]  lck_i,
  output logic              out_valid,
  output logic [VCH_W-1:0]  out_vch,
  output logic [FLIT_W-1:0] out_data,
  output logic [VCH_N-1:0]  rdy_o,
  output logic [VCH_N-1:0]  lck_o
`ifdef OUTPUTC_VC_CHK_EN
  ,
  output logic [VCH_N-1:0]  err_o
`endif
);

  localparam logic [1:0] C_HEADTAIL = 2'b00;
  localparam logic [1:0] C_HEAD     = 2'b01;
  localparam logic [1:0] C_TAIL     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  logic              r_out_valid;
  logic [VCH_W-1:0]  r_out_vch;
  logic [FLIT_W-1:0] r_out_data;
  logic [1:0]        w_in_type;

  assign w_in_type = in_data[FLIT_W-1 -: 2];

  // No backpressure: an idle cycle clears the link register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_vch   <= '0;
      r_out_data  <= '0;
    end else if (in_valid) begin
      r_out_valid <= 1'b1;
      r_out_vch   <= in_vch;
      r_out_data  <= in_data;
    end else begin
      r_out_valid <= 1'b0;
      r_out_vch   <= '0;
      r_out_data  <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_vch   = r_out_vch;
  assign out_data  = r_out_data;

  for (genvar v = 0; v < VCH_N; v++) begin : g_vc
    logic             w_send;
    logic             w_cred;
    logic             w_held;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;

    assign w_send = in_valid && (in_vch == VCH_W'(v));
    assign w_cred = cred_i[v];
    assign w_held = r_out_valid && (r_out_vch == VCH_W'(v));

    // Simultaneous send and credit cancel; both ends saturate.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_send && !w_cred) begin
        if (r_cnt != CNT_W'(BUF_DEPTH)) r_cnt <= r_cnt + 1'b1;
      end else if (w_cred && !w_send) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end

    if (RDY_PKT != 0) begin : g_rdy_pkt
      assign rdy_o[v] = (BUF_DEPTH - int'(r_cnt)) >= PKT_LEN;
    end else begin : g_rdy_flit
      assign rdy_o[v] = int'(r_cnt) < BUF_DEPTH;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_IDLE: begin
          if (w_send && w_in_type == C_HEAD)          w_state_nxt = ST_BUSY;
          else if (w_send && w_in_type == C_HEADTAIL) w_state_nxt = ST_DRAIN;
        end
        ST_BUSY: begin
          if (w_send && w_in_type == C_TAIL) w_state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Release only once the last flit has left the link register.
          if (!lck_i[v] && !w_held && !w_send) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    assign lck_o[v] = (r_state != ST_IDLE);

`ifdef OUTPUTC_VC_CHK_EN
    logic w_ovf;
    logic w_udf;
    logic w_proto;
    logic r_err;

    assign w_ovf   = w_send && (r_cnt == CNT_W'(BUF_DEPTH));
    assign w_udf   = w_cred && !w_send && (r_cnt == '0);
    assign w_proto = w_send &&
                     (((r_state == ST_IDLE) && w_in_type[1]) ||
                      ((r_state == ST_DRAIN) && !w_in_type[1]));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                           r_err <= 1'b0;
      else if (w_ovf || w_udf || w_proto) r_err <= 1'b1;
    end

    assign err_o[v] = r_err;

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (!rst && (w_ovf || w_udf || w_proto))
        $error("outputc_vc: VC %0d ovf=%0b udf=%0b proto=%0b", v, w_ovf, w_udf, w_proto);
    end
`endif
`endif
  end

endmodule
`default_nettype wire
